// File: rtl/store_unit_pkg.sv
// Shared definitions for the store path: default widths and the store FSM encoding.
package store_unit_pkg;

  localparam int unsigned STORE_BITS      = 8;
  localparam int unsigned STORE_ADDR_BITS = 8;
  localparam int unsigned STORE_DEPTH     = 2;
  localparam int unsigned STORE_TIMEOUT   = 16;

  typedef enum logic [0:0] {
    STORE_IDLE  = 1'b0,
    STORE_WRITE = 1'b1
  } store_state_e;

endpackage

// File: rtl/store_fifo.sv
// Store buffer: DEPTH entries of {addr, data}. Entries are also exposed in age order
// (index 0 = head / oldest) so the lookup can pick the youngest match.
module store_fifo #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [ADDR_BITS-1:0]         push_addr_i,
  input  logic [BITS-1:0]              push_data_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [ADDR_BITS-1:0]         head_addr_o,
  output logic [BITS-1:0]              head_data_o,
  output logic [DEPTH-1:0]             entry_valid_o,
  output logic [DEPTH*ADDR_BITS-1:0]   entry_addr_o,
  output logic [DEPTH*BITS-1:0]        entry_data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [BITS-1:0]      data_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;

  // Occupancy: unchanged on simultaneous push and pop.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Age-ordered read-out for the forwarding lookup.
  always_comb begin
    entry_valid_o = '0;
    entry_addr_o  = '0;
    entry_data_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid_o[i]                        = (CntW'(i) < count_q);
      entry_addr_o[i*ADDR_BITS +: ADDR_BITS] = addr_q[rd_ptr_q + PtrW'(i)];
      entry_data_o[i*BITS +: BITS]           = data_q[rd_ptr_q + PtrW'(i)];
    end
  end

  assign full_o      = (count_q == CntW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

endmodule

// File: rtl/store_unit.sv
// Store unit: buffers core stores, drains them to the data RAM one at a time with an
// ack timeout, and forwards the youngest buffered value to the fetcher's read path.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned BITS      = STORE_BITS,
  parameter int unsigned ADDR_BITS = STORE_ADDR_BITS,
  parameter int unsigned DEPTH     = STORE_DEPTH,
  parameter int unsigned TIMEOUT   = STORE_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_BITS-1:0] req_addr_i,
  input  logic [BITS-1:0]      req_data_i,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [BITS-1:0]      mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [ADDR_BITS-1:0] lookup_addr_i,
  output logic                 lookup_hit_o,
  output logic [BITS-1:0]      lookup_data_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  store_state_e         state_q;
  logic [TW-1:0]        tmo_q;
  logic                 done_q, err_q;

  logic                 fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic [ADDR_BITS-1:0] head_addr;
  logic [BITS-1:0]      head_data;
  logic [DEPTH-1:0]     entry_valid;
  logic [DEPTH*ADDR_BITS-1:0] entry_addr;
  logic [DEPTH*BITS-1:0]      entry_data;

  logic writing, push, ack, timeout, pop;

  // No bypass: a full buffer refuses even when the head pops this cycle.
  assign req_ready_o = !reset && !fifo_full;
  assign push        = req_valid_i && req_ready_o;
  assign writing     = (state_q == STORE_WRITE);
  assign ack         = writing && mem_ack_i;
  // An ack in the last allowed cycle wins over the timeout.
  assign timeout     = writing && !mem_ack_i && (tmo_q == TW'(TIMEOUT - 1));
  assign pop         = ack || timeout;

  store_fifo #(
    .BITS      (BITS),
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .push_addr_i   (req_addr_i),
    .push_data_i   (req_data_i),
    .pop_i         (pop),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .count_o       (fifo_count),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr),
    .entry_data_o  (entry_data)
  );

  // Drain FSM with per-entry timeout counter and registered done/err flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STORE_IDLE;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= ack;
      if (timeout) err_q <= 1'b1;
      unique case (state_q)
        STORE_IDLE: begin
          tmo_q <= '0;
          if (!fifo_empty) state_q <= STORE_WRITE;
        end
        STORE_WRITE: begin
          if (pop) begin
            tmo_q <= '0;
            // Keep writing if anything remains after the pop, counting a same-edge push.
            if (!push && (fifo_count == CntW'(1))) state_q <= STORE_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= STORE_IDLE;
      endcase
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match is kept.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i*ADDR_BITS +: ADDR_BITS] == lookup_addr_i)) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = entry_data[i*BITS +: BITS];
      end
    end
  end

  assign mem_we_o    = writing;
  assign mem_addr_o  = writing ? head_addr : '0;
  assign mem_wdata_o = writing ? head_data : '0;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = (fifo_count != '0) || writing;

endmodule
